// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler
// Time-multiplexed scan scheduler for a 4-digit seven-segment display.
// Two 4-digit pages are shown: page A (status) and page B (relay state).
// The pages alternate every PAGE_SCANS full scans. A rising edge on
// hold_req forces page B for HOLD_SCANS scans, starting at the next scan
// boundary. Each digit slot begins with GUARD cycles of all anodes off to
// avoid ghosting.
//
// Optional feature macro: SEG_BLINK_EN
//   When defined, a blink phase toggles every BLINK_SCANS scans. While the
//   phase is 1, digits selected by blink_mask stay dark for the whole slot.
//
// Ports:
//   mclk        in   system clock
//   rst         in   asynchronous active-high reset
//   digits_a    in   page A nibbles, digit d at [4d+3:4d]
//   digits_b    in   page B nibbles
//   dp_a, dp_b  in   decimal points per page (1 = lit)
//   hold_req    in   level input, rising edge requests a page B hold
//   blink_mask  in   per-digit blink enable (SEG_BLINK_EN only)
//   nib         out  nibble to the segment decoder
//   an          out  anodes, active-low
//   dp          out  decimal point, active-low
//   page        out  page shown, 0 = A, 1 = B
//   hold_busy   out  high while page B is held
module seg_scan_scheduler #(
  parameter int SCAN_DIV    = 100000,
  parameter int GUARD       = 16,
  parameter int PAGE_SCANS  = 250,
  parameter int HOLD_SCANS  = 750,
  parameter int BLINK_SCANS = 125
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [15:0] digits_a,
  input  logic [15:0] digits_b,
  input  logic [3:0]  dp_a,
  input  logic [3:0]  dp_b,
  input  logic        hold_req,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  nib,
  output logic [3:0]  an,
  output logic        dp,
  output logic        page,
  output logic        hold_busy
);

  localparam int PW      = $clog2(SCAN_DIV);
  localparam int CNT_MAX = (PAGE_SCANS > HOLD_SCANS) ? PAGE_SCANS : HOLD_SCANS;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // AUTO is split by the page it is showing so page is a pure state decode.
  typedef enum logic [1:0] {
    ST_AUTO_A = 2'd0,
    ST_AUTO_B = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic          hold_pend_q, hold_pend_d;
  logic          hold_in_q, hold_in_d;
  logic          hold_prev_q, hold_prev_d;

  logic [3:0]    an_q, an_d;
  logic [3:0]    nib_q, nib_d;
  logic          dp_q, dp_d;
  logic          page_q, page_d;
  logic          busy_q, busy_d;

  logic          tick_s;
  logic          boundary_s;
  logic          hold_rise_s;
  logic          blank_s;
  logic [15:0]   src_digits_s;
  logic [3:0]    src_dp_s;

  assign tick_s      = (presc_q == PW'(SCAN_DIV - 1));
  assign boundary_s  = tick_s && (idx_q == 2'd3);
  // Edge is taken on the registered copy of hold_req.
  assign hold_rise_s = hold_in_q & ~hold_prev_q;

  // Prescaler, digit index and hold request pipeline next values.
  always_comb begin
    presc_d     = presc_q;
    idx_d       = idx_q;
    hold_in_d   = hold_req;
    hold_prev_d = hold_in_q;
    if (tick_s) begin
      presc_d = {PW{1'b0}};
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
    end
  end

  // Pending hold: consumed at a boundary, while an edge in the same cycle
  // is kept for the following boundary.
  always_comb begin
    hold_pend_d = hold_pend_q;
    if (boundary_s) begin
      hold_pend_d = 1'b0;
    end else begin
      hold_pend_d = hold_pend_q;
    end
    if (hold_rise_s) begin
      hold_pend_d = 1'b1;
    end else begin
      hold_pend_d = hold_pend_d;
    end
  end

  // Page FSM next state; it only moves at scan boundaries and a pending
  // hold takes priority over page expiry.
  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    if (boundary_s) begin
      if (hold_pend_q) begin
        state_d    = ST_HOLD;
        scan_cnt_d = {CW{1'b0}};
      end else begin
        case (state_q)
          ST_AUTO_A, ST_AUTO_B: begin
            if (scan_cnt_q == CW'(PAGE_SCANS - 1)) begin
              state_d    = (state_q == ST_AUTO_A) ? ST_AUTO_B : ST_AUTO_A;
              scan_cnt_d = {CW{1'b0}};
            end else begin
              state_d    = state_q;
              scan_cnt_d = scan_cnt_q + CW'(1);
            end
          end
          ST_HOLD: begin
            if (scan_cnt_q == CW'(HOLD_SCANS - 1)) begin
              state_d    = ST_AUTO_A;
              scan_cnt_d = {CW{1'b0}};
            end else begin
              state_d    = ST_HOLD;
              scan_cnt_d = scan_cnt_q + CW'(1);
            end
          end
          default: begin
            state_d    = ST_AUTO_A;
            scan_cnt_d = {CW{1'b0}};
          end
        endcase
      end
    end else begin
      state_d    = state_q;
      scan_cnt_d = scan_cnt_q;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;

  // Blink phase advances every BLINK_SCANS scan boundaries.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (boundary_s) begin
      if (blink_cnt_q == BW'(BLINK_SCANS - 1)) begin
        blink_cnt_d = {BW{1'b0}};
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_ph_d  = blink_ph_q;
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
      blink_ph_d  = blink_ph_q;
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= {BW{1'b0}};
      blink_ph_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  assign blank_s = blink_ph_d & blink_mask[idx_d];
`else
  logic unused_s;
  assign blank_s  = 1'b0;
  assign unused_s = ^blink_mask ^ (BLINK_SCANS > 0);
`endif

  // Outputs are decoded from next-state values so the registered outputs
  // line up with the slot and page that start on the same edge.
  always_comb begin
    page_d       = (state_d != ST_AUTO_A);
    busy_d       = (state_d == ST_HOLD);
    src_digits_s = page_d ? digits_b : digits_a;
    src_dp_s     = page_d ? dp_b : dp_a;
    case (idx_d)
      2'd0:    nib_d = src_digits_s[3:0];
      2'd1:    nib_d = src_digits_s[7:4];
      2'd2:    nib_d = src_digits_s[11:8];
      2'd3:    nib_d = src_digits_s[15:12];
      default: nib_d = 4'h0;
    endcase
    dp_d = ~src_dp_s[idx_d];
    if (presc_d < PW'(GUARD)) begin
      an_d = 4'b1111;
    end else if (blank_s) begin
      an_d = 4'b1111;
    end else begin
      an_d = ~(4'b0001 << idx_d);
    end
  end

  // State, counter and output registers.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_AUTO_A;
      presc_q     <= {PW{1'b0}};
      idx_q       <= 2'd0;
      scan_cnt_q  <= {CW{1'b0}};
      hold_pend_q <= 1'b0;
      hold_in_q   <= 1'b0;
      hold_prev_q <= 1'b0;
      an_q        <= 4'b1111;
      nib_q       <= 4'h0;
      dp_q        <= 1'b1;
      page_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      scan_cnt_q  <= scan_cnt_d;
      hold_pend_q <= hold_pend_d;
      hold_in_q   <= hold_in_d;
      hold_prev_q <= hold_prev_d;
      an_q        <= an_d;
      nib_q       <= nib_d;
      dp_q        <= dp_d;
      page_q      <= page_d;
      busy_q      <= busy_d;
    end
  end

  assign an        = an_q;
  assign nib       = nib_q;
  assign dp        = dp_q;
  assign page      = page_q;
  assign hold_busy = busy_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Testbench for seg_scan_scheduler with small parameters. A reference model
// tracks the number of clock edges since reset: slot position comes from
// plain arithmetic on that count, and the page/hold behaviour is modelled
// once per scan boundary.
module tb_seg_scan_scheduler;
  localparam int SD = 4;
  localparam int GD = 1;
  localparam int PS = 2;
  localparam int HS = 3;
  localparam int BS = 1;

  logic        mclk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits_a = 16'h0;
  logic [15:0] digits_b = 16'h0;
  logic [3:0]  dp_a = 4'h0;
  logic [3:0]  dp_b = 4'h0;
  logic        hold_req = 1'b0;
  logic [3:0]  blink_mask = 4'h0;
  logic [3:0]  nib, an;
  logic        dp, page, hold_busy;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int mt, mcnt, mbcnt;
  bit mpage, mhold, mpend, mh1, mh2, mph;
  logic [3:0] e_an, e_nib;
  logic e_dp, e_page, e_busy;

  seg_scan_scheduler #(
    .SCAN_DIV(SD), .GUARD(GD), .PAGE_SCANS(PS), .HOLD_SCANS(HS), .BLINK_SCANS(BS)
  ) dut (
    .mclk(mclk), .rst(rst), .digits_a(digits_a), .digits_b(digits_b),
    .dp_a(dp_a), .dp_b(dp_b), .hold_req(hold_req), .blink_mask(blink_mask),
    .nib(nib), .an(an), .dp(dp), .page(page), .hold_busy(hold_busy)
  );

  always #5 mclk = ~mclk;

  task automatic model_reset();
    mt = 0; mcnt = 0; mbcnt = 0;
    mpage = 0; mhold = 0; mpend = 0; mh1 = 0; mh2 = 0; mph = 0;
    e_an = 4'hF; e_nib = 4'h0; e_dp = 1'b1; e_page = 1'b0; e_busy = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit bnd, rise;
    int nidx;
    bnd  = (mt % (4 * SD)) == (4 * SD - 1);
    rise = mh1 && !mh2;
    if (bnd) begin
      if (mpend) begin
        mhold = 1; mpage = 1; mcnt = 0;
      end else if (mhold) begin
        if (mcnt + 1 == HS) begin mhold = 0; mpage = 0; mcnt = 0; end
        else mcnt++;
      end else begin
        if (mcnt + 1 == PS) begin mpage = !mpage; mcnt = 0; end
        else mcnt++;
      end
      mpend = 0;
      if (mbcnt + 1 == BS) begin mph = !mph; mbcnt = 0; end
      else mbcnt++;
    end
    if (rise) mpend = 1;
    mh2 = mh1;
    mh1 = hold_req;
    mt++;
    nidx  = (mt / SD) % 4;
    e_an  = ((mt % SD) < GD) ? 4'hF : ~(4'b0001 << nidx);
`ifdef SEG_BLINK_EN
    if (mph && blink_mask[nidx]) e_an = 4'hF;
`endif
    e_nib  = mpage ? digits_b[4*nidx +: 4] : digits_a[4*nidx +: 4];
    e_dp   = mpage ? ~dp_b[nidx] : ~dp_a[nidx];
    e_page = mpage;
    e_busy = mhold;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge mclk);
    @(negedge mclk);
  endtask

  task automatic apply_reset();
    @(negedge mclk);
    #2 rst = 1'b1;
    #1 model_reset();
    @(negedge mclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge mclk);
    #2 rst = 1'b1;
    #1;
    if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an got %b want 1111", an); end
    n_chk++;
    if (nib !== 4'h0) begin n_fail++; $display("FAIL reset_nib got %h want 0", nib); end
    n_chk++;
    if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b want 1", dp); end
    n_chk++;
    if (page !== 1'b0) begin n_fail++; $display("FAIL reset_page got %b want 0", page); end
    n_chk++;
    if (hold_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", hold_busy); end
    n_chk++;
    model_reset();
    @(negedge mclk);
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] seq [4];
    seq = '{4'h1, 4'h2, 4'h3, 4'h4};
    digits_a = 16'h4321; dp_a = 4'b0101;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      cycle();
      if ({an, nib, dp, page, hold_busy} !== {e_an, e_nib, e_dp, e_page, e_busy}) begin
        n_fail++;
        $display("FAIL scan t=%0d got %b want %b", mt, {an, nib, dp, page, hold_busy}, {e_an, e_nib, e_dp, e_page, e_busy});
      end
      n_chk++;
      if (mt % SD == 2) begin
        if (nib !== seq[(mt / SD) % 4]) begin
          n_fail++; $display("FAIL scan_nib t=%0d got %h want %h", mt, nib, seq[(mt / SD) % 4]);
        end
        n_chk++;
      end
      if (mt % SD == 0) begin
        if (an !== 4'hF) begin n_fail++; $display("FAIL scan_guard t=%0d got %b want 1111", mt, an); end
        n_chk++;
      end
    end
  endtask

  task automatic test_auto_paging();
    digits_a = 16'h4321; digits_b = 16'h8765; dp_a = 4'h0; dp_b = 4'hF;
    apply_reset();
    while (mt < 70) begin
      cycle();
      if ({an, nib, dp, page, hold_busy} !== {e_an, e_nib, e_dp, e_page, e_busy}) begin
        n_fail++;
        $display("FAIL auto t=%0d got %b want %b", mt, {an, nib, dp, page, hold_busy}, {e_an, e_nib, e_dp, e_page, e_busy});
      end
      n_chk++;
      if (mt == 31) begin
        if (page !== 1'b0) begin n_fail++; $display("FAIL auto_before t=31 got %b want 0", page); end
        n_chk++;
      end
      if (mt == 32) begin
        if ({page, nib} !== {1'b1, 4'h5}) begin
          n_fail++; $display("FAIL auto_switch t=32 got page=%b nib=%h want page=1 nib=5", page, nib);
        end
        n_chk++;
      end
      if (mt == 64) begin
        if (page !== 1'b0) begin n_fail++; $display("FAIL auto_back t=64 got %b want 0", page); end
        n_chk++;
      end
    end
  endtask

  task automatic test_hold();
    int first_busy;
    first_busy = -1;
    digits_a = 16'h4321; digits_b = 16'h8765;
    apply_reset();
    while (mt < 70) begin
      if (mt == 5) hold_req = 1'b1;
      if (mt == 8) hold_req = 1'b0;
      cycle();
      if ({an, nib, dp, page, hold_busy} !== {e_an, e_nib, e_dp, e_page, e_busy}) begin
        n_fail++;
        $display("FAIL hold t=%0d got %b want %b", mt, {an, nib, dp, page, hold_busy}, {e_an, e_nib, e_dp, e_page, e_busy});
      end
      n_chk++;
      if (hold_busy === 1'b1 && first_busy < 0) first_busy = mt;
      if (mt == 16) begin
        if ({page, hold_busy} !== 2'b11) begin n_fail++; $display("FAIL hold_enter t=16 got %b want 11", {page, hold_busy}); end
        n_chk++;
      end
      if (mt == 63) begin
        if ({page, hold_busy} !== 2'b11) begin n_fail++; $display("FAIL hold_keep t=63 got %b want 11", {page, hold_busy}); end
        n_chk++;
      end
      if (mt == 64) begin
        if ({page, hold_busy} !== 2'b00) begin n_fail++; $display("FAIL hold_exit t=64 got %b want 00", {page, hold_busy}); end
        n_chk++;
      end
    end
    if (first_busy < 0 || first_busy - 5 > 4 * SD + 2) begin
      n_fail++; $display("FAIL hold_latency got first busy at t=%0d want <= %0d", first_busy, 5 + 4 * SD + 2);
    end
    n_chk++;
  endtask

  task automatic test_hold_on_boundary();
    apply_reset();
    while (mt < 40) begin
      if (mt == 14) hold_req = 1'b1;
      if (mt == 20) hold_req = 1'b0;
      cycle();
      if ({an, nib, dp, page, hold_busy} !== {e_an, e_nib, e_dp, e_page, e_busy}) begin
        n_fail++;
        $display("FAIL hold_bnd t=%0d got %b want %b", mt, {an, nib, dp, page, hold_busy}, {e_an, e_nib, e_dp, e_page, e_busy});
      end
      n_chk++;
      if (mt == 16) begin
        if (hold_busy !== 1'b0) begin n_fail++; $display("FAIL hold_bnd_defer t=16 got %b want 0", hold_busy); end
        n_chk++;
      end
      if (mt == 32) begin
        if (hold_busy !== 1'b1) begin n_fail++; $display("FAIL hold_bnd_apply t=32 got %b want 1", hold_busy); end
        n_chk++;
      end
    end
  endtask

  task automatic test_rehold();
    apply_reset();
    while (mt < 100) begin
      if (mt == 5) hold_req = 1'b1;
      if (mt == 8) hold_req = 1'b0;
      if (mt == 36) hold_req = 1'b1;
      if (mt == 40) hold_req = 1'b0;
      cycle();
      if ({an, nib, dp, page, hold_busy} !== {e_an, e_nib, e_dp, e_page, e_busy}) begin
        n_fail++;
        $display("FAIL rehold t=%0d got %b want %b", mt, {an, nib, dp, page, hold_busy}, {e_an, e_nib, e_dp, e_page, e_busy});
      end
      n_chk++;
      if (mt == 64 || mt == 95) begin
        if (hold_busy !== 1'b1) begin n_fail++; $display("FAIL rehold_keep t=%0d got %b want 1", mt, hold_busy); end
        n_chk++;
      end
      if (mt == 96) begin
        if (hold_busy !== 1'b0) begin n_fail++; $display("FAIL rehold_exit t=96 got %b want 0", hold_busy); end
        n_chk++;
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    digits_a = 16'hA5C3;
    apply_reset();
    while (mt < 22) begin
      hold_req = (mt >= 5 && mt < 8);
      cycle();
    end
    if (hold_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got busy=%b want 1", hold_busy); end
    n_chk++;
    #2 rst = 1'b1;
    #1;
    if ({an, page, hold_busy} !== {4'hF, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL midrst_async got an=%b page=%b busy=%b want 1111 0 0", an, page, hold_busy);
    end
    n_chk++;
    model_reset();
    @(negedge mclk);
    rst = 1'b0;
    while (mt < 20) begin
      cycle();
      if ({an, nib, dp, page, hold_busy} !== {e_an, e_nib, e_dp, e_page, e_busy}) begin
        n_fail++;
        $display("FAIL midrst t=%0d got %b want %b", mt, {an, nib, dp, page, hold_busy}, {e_an, e_nib, e_dp, e_page, e_busy});
      end
      n_chk++;
      if (mt == 1) begin
        if ({an, nib} !== {4'b1110, 4'h3}) begin n_fail++; $display("FAIL midrst_first t=1 got %b want 11100011", {an, nib}); end
        n_chk++;
      end
    end
  endtask

`ifdef SEG_BLINK_EN
  task automatic test_blink();
    blink_mask = 4'b0100;
    apply_reset();
    while (mt < 48) begin
      cycle();
      if ({an, nib, dp, page, hold_busy} !== {e_an, e_nib, e_dp, e_page, e_busy}) begin
        n_fail++;
        $display("FAIL blink t=%0d got %b want %b", mt, {an, nib, dp, page, hold_busy}, {e_an, e_nib, e_dp, e_page, e_busy});
      end
      n_chk++;
      if (mt == 9 || mt == 41) begin
        if (an !== 4'b1011) begin n_fail++; $display("FAIL blink_on t=%0d got %b want 1011", mt, an); end
        n_chk++;
      end
      if (mt == 25) begin
        if (an !== 4'b1111) begin n_fail++; $display("FAIL blink_off t=25 got %b want 1111", an); end
        n_chk++;
      end
      if (mt == 17) begin
        if (an !== 4'b1110) begin n_fail++; $display("FAIL blink_other t=17 got %b want 1110", an); end
        n_chk++;
      end
    end
    blink_mask = 4'h0;
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      digits_a   = 16'($urandom);
      digits_b   = 16'($urandom);
      dp_a       = 4'($urandom);
      dp_b       = 4'($urandom);
      blink_mask = 4'($urandom);
      if ($urandom_range(0, 39) == 0) hold_req = ~hold_req;
      cycle();
      if ({an, nib, dp, page, hold_busy} !== {e_an, e_nib, e_dp, e_page, e_busy}) begin
        n_fail++;
        $display("FAIL random t=%0d got %b want %b", mt, {an, nib, dp, page, hold_busy}, {e_an, e_nib, e_dp, e_page, e_busy});
      end
      n_chk++;
    end
    hold_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_auto_paging();
    test_hold();
    test_hold_on_boundary();
    test_rehold();
    test_reset_mid_hold();
`ifdef SEG_BLINK_EN
    test_blink();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
